// File: rtl/counter_capture.sv
// rtl/counter_capture.sv - event-line input capture of a free-running counter into a FWFT FIFO
//
// Purpose:
//    Synchronises an asynchronous event line, detects its rising edges and, while
//    armed, pushes the current counter value into a first-word fall-through FIFO.
//    Timestamps drain through a valid/ready stream. A sticky overflow flag records
//    any capture lost to a full FIFO.
//
// Optional feature (macro CAPTURE_DELTA_EN):
//    When defined, each entry holds (count - last accepted capture) mod 2^WIDTH
//    instead of the absolute count. The first capture after reset is absolute.
//
// Ports:
//    clk             in   clock, all logic on rising edge
//    reset           in   synchronous active-high reset
//    count           in   WIDTH counter value to timestamp
//    event_in        in   asynchronous event line, rising edge captures
//    arm             in   1 = captures enabled
//    out_data        out  WIDTH head-of-FIFO entry (don't-care when out_valid = 0)
//    out_valid       out  head entry valid
//    out_ready       in   consumer accepts head when out_valid & out_ready
//    level           out  entries stored, 0..DEPTH
//    overflow        out  sticky, a capture was dropped on a full FIFO
//    clear_overflow  in   clears overflow (a simultaneous drop wins)

module counter_capture #(
   parameter int WIDTH       = 16,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           count,
   input  logic                       event_in,
   input  logic                       arm,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       overflow,
   input  logic                       clear_overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   edge_det;

   logic [WIDTH-1:0]       mem [DEPTH];
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [LW-1:0]          level_q;
   logic                   overflow_q;

   logic                   full;
   logic                   push_req;
   logic                   pop;
   logic                   push;
   logic                   drop;
   logic [WIDTH-1:0]       wr_val;

   // Synchroniser chain plus one history flop for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], event_in};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;

   assign full     = (level_q == FULL_LEVEL);
   assign pop      = out_valid & out_ready;
   assign push_req = edge_det & arm;
   // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
   assign push     = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;

`ifdef CAPTURE_DELTA_EN
   logic [WIDTH-1:0] last_q;

   // Reference only moves on accepted pushes so drops never skew the next delta.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= '0;
      end else if (push) begin
         last_q <= count;
      end
   end

   assign wr_val = count - last_q;
`else
   assign wr_val = count;
`endif

   // Storage needs no reset: level/pointers define which slots are meaningful.
   // When full with a simultaneous pop, wr_ptr == rd_ptr and the slot being
   // overwritten is the head that is leaving this cycle.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_val;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            level_q <= level_q + 1'b1;
         end else if (pop && !push) begin
            level_q <= level_q - 1'b1;
         end
         if (drop) begin
            overflow_q <= 1'b1;
         end else if (clear_overflow) begin
            overflow_q <= 1'b0;
         end
      end
   end

   assign out_valid = (level_q != '0);
   assign out_data  = mem[rd_ptr];
   assign level     = level_q;
   assign overflow  = overflow_q;

endmodule
